// File: rtl/seq_pkg.sv
// Shared definitions for the 3-bit cyclic code stream: legal codes, checker
// FSM states and the legality test.
package seq_pkg;

  localparam logic [2:0] CODE_S0 = 3'b000;
  localparam logic [2:0] CODE_S1 = 3'b010;
  localparam logic [2:0] CODE_S2 = 3'b011;
  localparam logic [2:0] CODE_S3 = 3'b101;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCK   = 2'b10,
    SLIP   = 2'b11
  } state_t;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == CODE_S0) || (code == CODE_S1) ||
           (code == CODE_S2) || (code == CODE_S3);
  endfunction

endpackage

// File: rtl/seq_succ.sv
// Combinational successor lookup for the code cycle 000->010->011->101->000.
// Anything outside the cycle maps back to the cycle start.
module seq_succ
  import seq_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] succ
);

  always_comb begin
    succ = CODE_S0;
    case (code)
      CODE_S0: succ = CODE_S1;
      CODE_S1: succ = CODE_S2;
      CODE_S2: succ = CODE_S3;
      CODE_S3: succ = CODE_S0;
      default: succ = CODE_S0;
    endcase
  end

endmodule

// File: rtl/sequence_checker.sv
// Monitors a 3-bit cyclic code stream: hunts for alignment, verifies a run of
// good codes, then flywheels the expected code and counts deviations.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [2:0]       din,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       exp_code,
  output logic [1:0]       state_o
);

  localparam int GOOD_W = $clog2(LOCK_COUNT) + 1;
  localparam int BAD_W  = $clog2(LOSS_COUNT) + 1;
  localparam logic [GOOD_W-1:0] LOCK_LIM = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  LOSS_LIM = BAD_W'(LOSS_COUNT);

  state_t            state_reg, state_next;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic [BAD_W-1:0]  bad_cnt_reg, bad_cnt_next;
  logic [2:0]        exp_code_reg, exp_code_next;
  logic [ERR_W-1:0]  err_count_reg, err_count_next;
  logic              err_pulse_reg, err_pulse_next;
  logic              locked_reg, locked_next;

  logic [2:0]        din_succ;
  logic [2:0]        exp_succ;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;
  logic              match;

  // One lookup re-seeds from the incoming code, the other drives the flywheel.
  seq_succ u_succ_din (.code(din),          .succ(din_succ));
  seq_succ u_succ_exp (.code(exp_code_reg), .succ(exp_succ));

  assign match    = (din == exp_code_reg);
  assign good_inc = good_cnt_reg + GOOD_W'(1);
  assign bad_inc  = (state_reg == LOCK) ? BAD_W'(1) : bad_cnt_reg + BAD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
      exp_code_reg  <= CODE_S0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      good_cnt_reg  <= good_cnt_next;
      bad_cnt_reg   <= bad_cnt_next;
      exp_code_reg  <= exp_code_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
      locked_reg    <= locked_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    bad_cnt_next   = bad_cnt_reg;
    exp_code_next  = exp_code_reg;
    err_count_next = err_count_reg;
    err_pulse_next = 1'b0;

    if (din_valid) begin
      case (state_reg)
        HUNT: begin
          if (is_legal(din)) begin
            exp_code_next = din_succ;
            good_cnt_next = GOOD_W'(1);
            state_next    = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_code_next = din_succ;
            if (good_inc == LOCK_LIM) begin
              good_cnt_next = '0;
              state_next    = LOCK;
            end else begin
              good_cnt_next = good_inc;
            end
          end else if (is_legal(din)) begin
            exp_code_next = din_succ;
            good_cnt_next = GOOD_W'(1);
          end else begin
            state_next = HUNT;
          end
        end
        default: begin  // LOCK and SLIP share the flywheel and error path
          exp_code_next = exp_succ;
          if (match) begin
            bad_cnt_next = '0;
            state_next   = LOCK;
          end else begin
            err_pulse_next = 1'b1;
            if (err_count_reg != {ERR_W{1'b1}})
              err_count_next = err_count_reg + ERR_W'(1);
            if (bad_inc >= LOSS_LIM) begin
              bad_cnt_next = '0;
              state_next   = HUNT;
            end else begin
              bad_cnt_next = bad_inc;
              state_next   = SLIP;
            end
          end
        end
      endcase
    end

    locked_next = (state_next == LOCK) || (state_next == SLIP);
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign exp_code  = exp_code_reg;
  assign state_o   = state_reg;

endmodule
